wb_stage_pipe: RTL

//  Parametrised write-back stage: MEM/WB pipeline register plus DEPTH-entry FIFO

---
 rtl/wb_stage_pipe.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: MEM/WB pipeline register plus a DEPTH-entry result FIFO that
// feeds the register-file write port. Result source selection and load
// alignment happen on entry, so the FIFO stores final write-back values.
// Optional feature macro: WB_BYPASS_EN (adds fwd_valid/fwd_rd/fwd_data, which
// expose the newest buffered entry that will really write the register file).
module wb_stage_pipe #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 2,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [XLEN-1:0]       in_alu,
  input  logic [XLEN-1:0]       in_mem,
  input  logic [XLEN-1:0]       in_pc4,
  input  logic [XLEN-1:0]       in_csr,
  input  logic [1:0]            in_wb_sel,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  rf_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata,
`ifdef WB_BYPASS_EN
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_rd,
  output logic [XLEN-1:0]       fwd_data,
`endif
  output logic [CNT_W-1:0]      retired
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0]         data_q [DEPTH];
  logic [XLEN-1:0]         data_d [DEPTH];
  logic [REG_ADDR_W-1:0]   rd_q [DEPTH];
  logic [REG_ADDR_W-1:0]   rd_d [DEPTH];
  logic [DEPTH-1:0]        we_q, we_d;
  logic                    in_ready_q, in_ready_d;
  logic                    rf_we_q, rf_we_d;
  logic [REG_ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]         rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0]        retired_q, retired_d;

  logic [XLEN-1:0]         entry_data;
  logic [XLEN-1:0]         load_data;
  logic [7:0]              byte_v;
  logic [15:0]             half_v;
  logic                    empty, push, pop;
  logic [AW-1:0]           wr_idx, rd_idx;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];
  // in_ready_q is the registered !full, so a same-cycle pop cannot reopen it.
  assign push   = in_valid && in_ready_q && !flush;
  assign pop    = !empty && !rf_stall && !flush;

  // Select the write-back source and align/extend load data before storage.
  always_comb begin
    byte_v = in_mem[{in_addr_lo, 3'b000} +: 8];
    half_v = in_addr_lo[1] ? in_mem[31:16] : in_mem[15:0];
    case (in_funct3)
      3'b000:  load_data = {{(XLEN-8){byte_v[7]}}, byte_v};
      3'b001:  load_data = {{(XLEN-16){half_v[15]}}, half_v};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_v};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, half_v};
      default: load_data = in_mem;
    endcase
    case (in_wb_sel)
      2'd0:    entry_data = in_alu;
      2'd1:    entry_data = load_data;
      2'd2:    entry_data = in_pc4;
      2'd3:    entry_data = in_csr;
      default: entry_data = '0;
    endcase
  end

  // Next-state for FIFO storage, pointers, drain register and retire counter.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    data_d     = data_q;
    rd_d       = rd_q;
    we_d       = we_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    retired_d  = retired_q;
    if (pop) begin
      rf_we_d    = we_q[rd_idx];
      rf_waddr_d = rd_q[rd_idx];
      rf_wdata_d = data_q[rd_idx];
      rd_ptr_d   = rd_ptr_q + (AW+1)'(1);
      retired_d  = retired_q + CNT_W'(1);
    end
    if (push) begin
      data_d[wr_idx] = entry_data;
      rd_d[wr_idx]   = in_rd;
      // x0 and non-writing entries still occupy a slot but never assert rf_we.
      we_d[wr_idx]   = in_reg_write && (in_rd != '0);
      wr_ptr_d       = wr_ptr_q + (AW+1)'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
    in_ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      we_q       <= '0;
      in_ready_q <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      retired_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      we_q       <= we_d;
      in_ready_q <= in_ready_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      retired_q  <= retired_d;
      data_q     <= data_d;
      rd_q       <= rd_d;
    end
  end

  assign in_ready = in_ready_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign retired  = retired_q;

`ifdef WB_BYPASS_EN
  logic [AW:0]   occ;
  logic [AW-1:0] scan_idx;
  assign occ = wr_ptr_q - rd_ptr_q;

  // Scan oldest to newest so the last writing entry found is the newest one.
  always_comb begin
    fwd_valid = 1'b0;
    fwd_rd    = '0;
    fwd_data  = '0;
    scan_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx = rd_idx + AW'(k);
      if (((AW+1)'(k) < occ) && we_q[scan_idx]) begin
        fwd_valid = 1'b1;
        fwd_rd    = rd_q[scan_idx];
        fwd_data  = data_q[scan_idx];
      end
    end
  end
`endif

endmodule
